// File: rtl/rob_pkg.sv
// Reorder buffer shared types and sizes.
// Entry count, field widths and pointer helpers.
package rob_pkg;

  localparam int RobDepth      = 16;
  localparam int RobAddrLength = 3;
  localparam int RdLength      = 4;
  localparam int PcLength      = 31;
  localparam int DataLength    = 31;

  typedef logic [RobAddrLength:0]   idx_t;
  typedef logic [RobAddrLength+1:0] cnt_t;
  typedef logic [PcLength:0]        pc_t;
  typedef logic [DataLength:0]      data_t;
  typedef logic [RdLength:0]        rd_t;

  // Power-of-two depth: plain overflow is the wrap.
  function automatic idx_t idx_inc(idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/rob_if.sv
// ROB bus: decoder issue, ALU/SLB CDB, RF commit, fetch redirect.
// master = environment side, slave = rob.
interface rob_if
  import rob_pkg::*;
();

  logic  is_empty_from_decoder;
  pc_t   pc_from_decoder;
  rd_t   rd_from_decoder;
  logic  is_full_to_decoder;

  logic  valid_from_alu;
  pc_t   pc_from_alu;
  data_t data_from_alu;
  logic  is_jump_from_alu;
  pc_t   target_from_alu;

  logic  valid_from_slb;
  pc_t   pc_from_slb;
  data_t data_from_slb;

  logic  is_commit_to_rf;
  rd_t   rd_to_rf;
  data_t data_to_rf;
  pc_t   pc_to_rf;
  logic  is_exception_to_rf;
  pc_t   target_pc_to_fetch;

  modport master (
    output is_empty_from_decoder,
    output pc_from_decoder,
    output rd_from_decoder,
    input  is_full_to_decoder,
    output valid_from_alu,
    output pc_from_alu,
    output data_from_alu,
    output is_jump_from_alu,
    output target_from_alu,
    output valid_from_slb,
    output pc_from_slb,
    output data_from_slb,
    input  is_commit_to_rf,
    input  rd_to_rf,
    input  data_to_rf,
    input  pc_to_rf,
    input  is_exception_to_rf,
    input  target_pc_to_fetch
  );

  modport slave (
    input  is_empty_from_decoder,
    input  pc_from_decoder,
    input  rd_from_decoder,
    output is_full_to_decoder,
    input  valid_from_alu,
    input  pc_from_alu,
    input  data_from_alu,
    input  is_jump_from_alu,
    input  target_from_alu,
    input  valid_from_slb,
    input  pc_from_slb,
    input  data_from_slb,
    output is_commit_to_rf,
    output rd_to_rf,
    output data_to_rf,
    output pc_to_rf,
    output is_exception_to_rf,
    output target_pc_to_fetch
  );

endinterface

// File: rtl/rob_tag_match.sv
// Finds the oldest live, not-ready entry whose pc equals tag.
// Ports: valid/ready/pc tables, head, req+tag in; hit+idx out.
module rob_tag_match
  import rob_pkg::*;
(
  input  logic [RobDepth-1:0] valid,
  input  logic [RobDepth-1:0] ready,
  input  pc_t                 pc_tab [RobDepth],
  input  idx_t                head,
  input  logic                req,
  input  pc_t                 tag,
  output logic                hit,
  output idx_t                idx
);

  idx_t k;

  // Walk from head so duplicate tags resolve to the oldest.
  always_comb begin
    hit = 1'b0;
    idx = head;
    k   = head;
    for (int i = 0; i < RobDepth; i++) begin
      k = head + idx_t'(i);
      if (!hit && req && valid[k] && !ready[k]
          && pc_tab[k] == tag) begin
        hit = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order issue, CDB capture, in-order retire.
// Ports: clk, rst, rob_if.slave bus (decoder/alu/slb/rf/fetch).
module rob
  import rob_pkg::*;
(
  input  logic clk,
  input  logic rst,
  rob_if.slave bus
);

  logic [RobDepth-1:0] valid_q;
  logic [RobDepth-1:0] ready_q;
  logic [RobDepth-1:0] jump_q;
  pc_t   pc_q     [RobDepth];
  rd_t   rd_q     [RobDepth];
  data_t data_q   [RobDepth];
  pc_t   target_q [RobDepth];

  idx_t head_q;
  idx_t tail_q;
  cnt_t count_q;

  logic  commit_q;
  rd_t   rd_o_q;
  data_t data_o_q;
  pc_t   pc_o_q;
  logic  exc_q;
  pc_t   tgt_o_q;

  logic issue;
  logic retire;
  logic flush;
  logic alu_hit;
  logic slb_hit;
  logic slb_wr;
  idx_t alu_idx;
  idx_t slb_idx;

  rob_tag_match u_alu_match (
    .valid  (valid_q),
    .ready  (ready_q),
    .pc_tab (pc_q),
    .head   (head_q),
    .req    (bus.valid_from_alu),
    .tag    (bus.pc_from_alu),
    .hit    (alu_hit),
    .idx    (alu_idx)
  );

  rob_tag_match u_slb_match (
    .valid  (valid_q),
    .ready  (ready_q),
    .pc_tab (pc_q),
    .head   (head_q),
    .req    (bus.valid_from_slb),
    .tag    (bus.pc_from_slb),
    .hit    (slb_hit),
    .idx    (slb_idx)
  );

  assign issue  = !bus.is_empty_from_decoder
                  && (count_q < cnt_t'(RobDepth));
  assign retire = valid_q[head_q] && ready_q[head_q];
  assign flush  = retire && jump_q[head_q];
  // ALU wins when both ports land on one entry.
  assign slb_wr = slb_hit
                  && !(alu_hit && alu_idx == slb_idx);

  // One slot of slack for the decoder's issue latency.
  assign bus.is_full_to_decoder =
    count_q >= cnt_t'(RobDepth - 1);

  assign bus.is_commit_to_rf    = commit_q;
  assign bus.rd_to_rf           = rd_o_q;
  assign bus.data_to_rf         = data_o_q;
  assign bus.pc_to_rf           = pc_o_q;
  assign bus.is_exception_to_rf = exc_q;
  assign bus.target_pc_to_fetch = tgt_o_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      ready_q  <= '0;
      jump_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
      rd_o_q   <= '0;
      data_o_q <= '0;
      pc_o_q   <= '0;
      exc_q    <= 1'b0;
      tgt_o_q  <= '0;
    end else begin
      commit_q <= retire;
      exc_q    <= flush;
      if (retire) begin
        rd_o_q   <= rd_q[head_q];
        pc_o_q   <= pc_q[head_q];
        data_o_q <= (rd_q[head_q] == '0)
                    ? '0 : data_q[head_q];
      end
      if (flush) begin
        tgt_o_q <= target_q[head_q];
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (retire) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= idx_inc(head_q);
        end
        if (issue) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          jump_q[tail_q]  <= 1'b0;
          tail_q          <= idx_inc(tail_q);
        end
        if (alu_hit) begin
          ready_q[alu_idx] <= 1'b1;
          jump_q[alu_idx]  <= bus.is_jump_from_alu;
        end
        if (slb_wr) begin
          ready_q[slb_idx] <= 1'b1;
        end
        if (issue && !retire) begin
          count_q <= count_q + cnt_t'(1);
        end else if (retire && !issue) begin
          count_q <= count_q - cnt_t'(1);
        end
      end
    end
  end

  // Payload only matters while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_q[tail_q] <= bus.pc_from_decoder;
      rd_q[tail_q] <= bus.rd_from_decoder;
    end
    if (alu_hit) begin
      data_q[alu_idx]   <= bus.data_from_alu;
      target_q[alu_idx] <= bus.target_from_alu;
    end
    if (slb_wr) begin
      data_q[slb_idx] <= bus.data_from_slb;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob with a commit scoreboard.
// Expected retires are queued in program order.
module tb_rob;

  logic clk;
  logic rst;

  rob_if bus ();

  rob dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb [$];
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.is_empty_from_decoder = 1'b1;
    bus.pc_from_decoder       = '0;
    bus.rd_from_decoder       = '0;
    bus.valid_from_alu        = 1'b0;
    bus.pc_from_alu           = '0;
    bus.data_from_alu         = '0;
    bus.is_jump_from_alu      = 1'b0;
    bus.target_from_alu       = '0;
    bus.valid_from_slb        = 1'b0;
    bus.pc_from_slb           = '0;
    bus.data_from_slb         = '0;
  endtask

  task automatic set_issue(input logic [31:0] pc,
                           input logic [4:0] rd);
    bus.is_empty_from_decoder = 1'b0;
    bus.pc_from_decoder       = pc;
    bus.rd_from_decoder       = rd;
  endtask

  task automatic set_alu(input logic [31:0] pc,
                         input logic [31:0] d,
                         input logic j,
                         input logic [31:0] t);
    bus.valid_from_alu   = 1'b1;
    bus.pc_from_alu      = pc;
    bus.data_from_alu    = d;
    bus.is_jump_from_alu = j;
    bus.target_from_alu  = t;
  endtask

  task automatic set_slb(input logic [31:0] pc,
                         input logic [31:0] d);
    bus.valid_from_slb = 1'b1;
    bus.pc_from_slb    = pc;
    bus.data_from_slb  = d;
  endtask

  task automatic issue(input logic [31:0] pc,
                       input logic [4:0] rd);
    set_issue(pc, rd);
    tick();
    idle();
  endtask

  task automatic alu_wb(input logic [31:0] pc,
                        input logic [31:0] d);
    set_alu(pc, d, 1'b0, 32'h0);
    tick();
    idle();
  endtask

  task automatic slb_wb(input logic [31:0] pc,
                        input logic [31:0] d);
    set_slb(pc, d);
    tick();
    idle();
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [4:0] rd,
                      input logic [31:0] d,
                      input logic e,
                      input logic [31:0] t);
    exp_t x;
    x.pc   = pc;
    x.rd   = rd;
    x.data = d;
    x.exc  = e;
    x.tgt  = t;
    sb.push_back(x);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard side: every retire must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.is_commit_to_rf) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", bus.pc_to_rf, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_pc", bus.pc_to_rf, e.pc);
          chk("commit_rd", 32'(bus.rd_to_rf), 32'(e.rd));
          chk("commit_data", bus.data_to_rf, e.data);
          chk("commit_exc", 32'(bus.is_exception_to_rf),
              32'(e.exc));
          if (e.exc) begin
            chk("commit_target", bus.target_pc_to_fetch, e.tgt);
          end
        end
      end else if (bus.is_exception_to_rf) begin
        chk("exc_without_commit", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_commit", 32'(bus.is_commit_to_rf), 32'd0);
    chk("rst_full", 32'(bus.is_full_to_decoder), 32'd0);
    chk("rst_exc", 32'(bus.is_exception_to_rf), 32'd0);
    chk("rst_pc", bus.pc_to_rf, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // In-order retire with out-of-order writeback.
    issue(32'h0, 5'd1);
    issue(32'h4, 5'd2);
    issue(32'h8, 5'd3);
    push(32'h0, 5'd1, 32'd10, 1'b0, 32'h0);
    push(32'h4, 5'd2, 32'd20, 1'b0, 32'h0);
    push(32'h8, 5'd3, 32'd30, 1'b0, 32'h0);
    alu_wb(32'h8, 32'd30);
    chk("io_no_commit_a", 32'(bus.is_commit_to_rf), 32'd0);
    tick();
    chk("io_no_commit_b", 32'(bus.is_commit_to_rf), 32'd0);
    alu_wb(32'h0, 32'd10);
    chk("io_wb_latency", 32'(bus.is_commit_to_rf), 32'd0);
    tick();
    chk("io_commit0", 32'(bus.is_commit_to_rf), 32'd1);
    chk("io_commit0_pc", bus.pc_to_rf, 32'h0);
    alu_wb(32'h4, 32'd20);
    chk("io_gap", 32'(bus.is_commit_to_rf), 32'd0);
    tick();
    chk("io_commit1_pc", bus.pc_to_rf, 32'h4);
    tick();
    chk("io_commit2", 32'(bus.is_commit_to_rf), 32'd1);
    chk("io_commit2_pc", bus.pc_to_rf, 32'h8);
    tick();
    chk("io_pulse_end", 32'(bus.is_commit_to_rf), 32'd0);
    drain(10);

    // Fill to the full threshold, retire some, wrap.
    for (int i = 0; i < 18; i++) begin
      push(32'h1000 + 32'(4 * i), 5'(i + 1),
           32'hA500_0000 | 32'(i), 1'b0, 32'h0);
    end
    for (int i = 0; i < 14; i++) begin
      issue(32'h1000 + 32'(4 * i), 5'(i + 1));
    end
    chk("full_at14", 32'(bus.is_full_to_decoder), 32'd0);
    issue(32'h1000 + 32'(4 * 14), 5'd15);
    chk("full_at15", 32'(bus.is_full_to_decoder), 32'd1);
    for (int i = 0; i < 3; i++) begin
      alu_wb(32'h1000 + 32'(4 * i), 32'hA500_0000 | 32'(i));
    end
    tick();
    chk("full_at12", 32'(bus.is_full_to_decoder), 32'd0);
    issue(32'h1000 + 32'(4 * 15), 5'd16);
    issue(32'h1000 + 32'(4 * 16), 5'd17);
    chk("full_at14b", 32'(bus.is_full_to_decoder), 32'd0);
    issue(32'h1000 + 32'(4 * 17), 5'd18);
    chk("full_at15b", 32'(bus.is_full_to_decoder), 32'd1);
    for (int i = 3; i < 18; i++) begin
      if (i % 2 == 0) begin
        alu_wb(32'h1000 + 32'(4 * i), 32'hA500_0000 | 32'(i));
      end else begin
        slb_wb(32'h1000 + 32'(4 * i), 32'hA500_0000 | 32'(i));
      end
    end
    drain(40);

    // Both CDB ports, a retire and an issue on one edge.
    push(32'h0C, 5'd4, 32'hC0C0, 1'b0, 32'h0);
    push(32'h10, 5'd5, 32'h1010, 1'b0, 32'h0);
    push(32'h14, 5'd6, 32'h1414, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      push(32'h2000 + 32'(4 * i), 5'd8,
           32'h2000 + 32'(i), 1'b0, 32'h0);
    end
    push(32'h18, 5'd7, 32'h1818, 1'b0, 32'h0);
    issue(32'h0C, 5'd4);
    issue(32'h10, 5'd5);
    issue(32'h14, 5'd6);
    for (int i = 0; i < 11; i++) begin
      issue(32'h2000 + 32'(4 * i), 5'd8);
    end
    chk("sim_count14", 32'(bus.is_full_to_decoder), 32'd0);
    alu_wb(32'h0C, 32'hC0C0);
    set_alu(32'h10, 32'h1010, 1'b0, 32'h0);
    set_slb(32'h14, 32'h1414);
    set_issue(32'h18, 5'd7);
    tick();
    idle();
    chk("sim_commit", 32'(bus.is_commit_to_rf), 32'd1);
    chk("sim_commit_pc", bus.pc_to_rf, 32'h0C);
    chk("sim_count_kept", 32'(bus.is_full_to_decoder), 32'd0);
    for (int i = 0; i < 11; i++) begin
      slb_wb(32'h2000 + 32'(4 * i), 32'h2000 + 32'(i));
    end
    alu_wb(32'h18, 32'h1818);
    drain(40);

    // Taken branch at head flushes younger work.
    issue(32'h20, 5'd1);
    issue(32'h24, 5'd2);
    issue(32'h28, 5'd3);
    push(32'h20, 5'd1, 32'h77, 1'b1, 32'h100);
    alu_wb(32'h24, 32'h5);
    set_alu(32'h20, 32'h77, 1'b1, 32'h100);
    tick();
    idle();
    chk("br_wait", 32'(bus.is_commit_to_rf), 32'd0);
    set_issue(32'h2C, 5'd4);
    set_slb(32'h28, 32'h99);
    tick();
    idle();
    chk("br_commit", 32'(bus.is_commit_to_rf), 32'd1);
    chk("br_exc", 32'(bus.is_exception_to_rf), 32'd1);
    chk("br_target", bus.target_pc_to_fetch, 32'h100);
    chk("br_full", 32'(bus.is_full_to_decoder), 32'd0);
    tick();
    chk("br_exc_pulse", 32'(bus.is_exception_to_rf), 32'd0);
    chk("br_commit_pulse", 32'(bus.is_commit_to_rf), 32'd0);
    alu_wb(32'h28, 32'h33);
    tick();
    chk("br_stale_wb", 32'(bus.is_commit_to_rf), 32'd0);
    for (int i = 0; i < 15; i++) begin
      push(32'h3000 + 32'(4 * i), 5'd10,
           32'h3000 + 32'(i), 1'b0, 32'h0);
    end
    for (int i = 0; i < 14; i++) begin
      issue(32'h3000 + 32'(4 * i), 5'd10);
    end
    chk("br_cnt14", 32'(bus.is_full_to_decoder), 32'd0);
    issue(32'h3000 + 32'(4 * 14), 5'd10);
    chk("br_cnt15", 32'(bus.is_full_to_decoder), 32'd1);
    for (int i = 0; i < 15; i++) begin
      alu_wb(32'h3000 + 32'(4 * i), 32'h3000 + 32'(i));
    end
    drain(40);

    // rd=0 forces zero data; duplicate tags hit the oldest.
    issue(32'h40, 5'd0);
    issue(32'h40, 5'd9);
    push(32'h40, 5'd0, 32'h0, 1'b0, 32'h0);
    push(32'h40, 5'd9, 32'hBEEF, 1'b0, 32'h0);
    alu_wb(32'h40, 32'hDEAD);
    tick();
    chk("rd0_commit", 32'(bus.is_commit_to_rf), 32'd1);
    chk("rd0_data", bus.data_to_rf, 32'h0);
    tick();
    tick();
    chk("dup_younger_wait", 32'(bus.is_commit_to_rf), 32'd0);
    alu_wb(32'h40, 32'hBEEF);
    drain(10);
    chk("hold_data", bus.data_to_rf, 32'hBEEF);
    chk("hold_rd", 32'(bus.rd_to_rf), 32'd9);

    // Async reset with live, ready entries.
    for (int i = 0; i < 5; i++) begin
      issue(32'h300 + 32'(4 * i), 5'(11 + i));
    end
    for (int i = 1; i < 5; i++) begin
      alu_wb(32'h300 + 32'(4 * i), 32'(i));
    end
    alu_wb(32'h300, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_commit", 32'(bus.is_commit_to_rf), 32'd0);
    chk("ar_rd", 32'(bus.rd_to_rf), 32'd0);
    chk("ar_data", bus.data_to_rf, 32'd0);
    chk("ar_pc", bus.pc_to_rf, 32'd0);
    chk("ar_target", bus.target_pc_to_fetch, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_no_commit", 32'(bus.is_commit_to_rf), 32'd0);
    end
    chk("ar_full", 32'(bus.is_full_to_decoder), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
